// File: rtl/sound_req_sequencer.sv
// Buzzer request sequencer: queues one-cycle sound events and plays each for its melody length, then a silent gap.
// Optional feature: define SND_PREEMPT_EN so a code-7 (game over) event flushes the queue and preempts playback.
module sound_req_sequencer #(
    parameter int BEAT_CYCLES = 6250002,
    parameter int LEN_LONG    = 64,
    parameter int LEN_SHORT   = 48,
    parameter int GAP_BEATS   = 2,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    input  logic [2:0] ev_code,
    output logic       ev_ready,
    output logic       ev_drop,
    output logic [2:0] sound_code,
    output logic       play_sound,
    output logic       busy
);
    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int BW = $clog2(LEN_LONG + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [BW-1:0]   len_q, len_d;
    logic [2:0]      code_q, code_d;
    logic            play_q, play_d;
    logic            drop_q, drop_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [2:0]      mem_q [DEPTH];
    logic [2:0]      mem_d [DEPTH];
    logic            full;
    logic            push;
    logic            pop;

    assign full = (cnt_q == NW'(DEPTH));
    assign push = ev_valid && (ev_code != 3'd0) && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            code_q   <= '0;
            play_q   <= 1'b0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            code_q   <= code_d;
            play_q   <= play_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        beat_d   = beat_q;
        len_d    = len_q;
        code_d   = code_q;
        play_d   = play_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        pop      = 1'b0;
        drop_d   = ev_valid && (ev_code != 3'd0) && full;

        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    code_d  = mem_q[rd_ptr_q];
                    play_d  = 1'b1;
                    cyc_d   = '0;
                    beat_d  = '0;
                    len_d   = (mem_q[rd_ptr_q] == 3'd1) ? BW'(LEN_LONG) : BW'(LEN_SHORT);
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (beat_q == len_q - BW'(1)) begin
                        beat_d  = '0;
                        play_d  = 1'b0;
                        code_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (beat_q == GAP_LAST) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = ev_code;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) cnt_d = cnt_q + NW'(1);
        else if (pop && !push) cnt_d = cnt_q - NW'(1);

`ifdef SND_PREEMPT_EN
        // Game over wins even against a full queue: leave only the 7 queued and silence via GAP.
        if (ev_valid && (ev_code == 3'd7)) begin
            state_d         = S_GAP;
            cyc_d           = '0;
            beat_d          = '0;
            play_d          = 1'b0;
            code_d          = '0;
            drop_d          = 1'b0;
            mem_d[rd_ptr_q] = 3'd7;
            rd_ptr_d        = rd_ptr_q;
            wr_ptr_d        = rd_ptr_q + AW'(1);
            cnt_d           = NW'(1);
        end
`endif
    end

    assign ev_ready   = !full;
    assign ev_drop    = drop_q;
    assign sound_code = code_q;
    assign play_sound = play_q;
    assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
endmodule

// File: tb/tb_sound_req_sequencer.sv
// Scoreboard bench for sound_req_sequencer: a timestamp-based queue model predicts each played sound
// and per-cycle busy/ready/drop levels; a negedge monitor compares what the DUT presents.
module tb_sound_req_sequencer;
    localparam int BC = 4;
    localparam int LL = 64;
    localparam int LS = 48;
    localparam int GB = 2;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic [2:0] ev_code = 3'd0;
    logic       ev_ready, ev_drop, play_sound, busy;
    logic [2:0] sound_code;

    sound_req_sequencer #(
        .BEAT_CYCLES(BC), .LEN_LONG(LL), .LEN_SHORT(LS), .GAP_BEATS(GB), .DEPTH(DP)
    ) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_ready(ev_ready), .ev_drop(ev_drop), .sound_code(sound_code),
        .play_sound(play_sound), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int start; int dur; } snd_t;
    typedef struct { bit busy; bit ready; bit drop; } lvl_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_n = -1;
    bit   mon_en = 1'b0;
    int   snd_seen = 0;
    snd_t exp_snd[$];
    lvl_t exp_lvl[$];
    int   mq[$];
    int   idle_from = 0;
    bit   drop_pend = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
        end
    endtask

    // Reference: the player is free from idle_from on; a pop at cycle t plays over [t+1, t+1+len*BC).
    task automatic model(input bit v, input int c);
        int   sz = mq.size();
        lvl_t l;
        snd_t s;
        bit   pre = 1'b0;
        l.busy = (cyc_n < idle_from) || (sz > 0);
        l.ready = (sz < DP);
        l.drop = drop_pend;
        drop_pend = 1'b0;
        exp_lvl.push_back(l);
`ifdef SND_PREEMPT_EN
        pre = v && (c == 7);
`endif
        if (pre) begin
            if (exp_snd.size() > 0 && cyc_n < exp_snd[$].start + exp_snd[$].dur)
                exp_snd[exp_snd.size()-1].dur = cyc_n + 1 - exp_snd[$].start;
            mq.delete();
            mq.push_back(7);
            idle_from = cyc_n + 1 + GB * BC;
        end else begin
            if (cyc_n >= idle_from && sz > 0) begin
                s.code = mq.pop_front();
                s.start = cyc_n + 1;
                s.dur = ((s.code == 1) ? LL : LS) * BC;
                exp_snd.push_back(s);
                idle_from = s.start + s.dur + GB * BC;
            end
            if (v && c != 0) begin
                if (sz < DP) mq.push_back(c);
                else drop_pend = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [2:0] c);
        @(posedge clk);
        #1;
        cyc_n++;
        ev_valid = v;
        ev_code = c;
        model(v, int'(c));
        mon_en = 1'b1;
    endtask

    task automatic idle_until(input int t);
        while (cyc_n < t) step(1'b0, 3'($urandom_range(0, 7)));
    endtask

    task automatic drain();
        int n = 0;
        while (!(cyc_n >= idle_from && mq.size() == 0) && n < 5000) begin
            step(1'b0, 3'($urandom_range(0, 7)));
            n++;
        end
        repeat (3) step(1'b0, 3'd0);
        chk("drain_pending_sounds", exp_snd.size(), 0);
    endtask

    task automatic do_reset(input int hold);
        mon_en = 1'b0;
        rst = 1'b1;
        ev_valid = 1'b0;
        ev_code = 3'd0;
        #1;
        chk("rst_play_sound", int'(play_sound), 0);
        chk("rst_sound_code", int'(sound_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ev_ready", int'(ev_ready), 1);
        chk("rst_ev_drop", int'(ev_drop), 0);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        exp_snd.delete();
        exp_lvl.delete();
        idle_from = 0;
        drop_pend = 1'b0;
        snd_seen = 0;
        cyc_n = -1;
    endtask

    initial begin : monitor
        lvl_t l;
        snd_t s;
        bit   playing;
        int   pst;
        int   pcode;
        playing = 1'b0;
        pst = 0;
        pcode = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                playing = 1'b0;
            end else begin
                if (exp_lvl.size() == 0) begin
                    chk("lvl_queue_depth", exp_lvl.size(), 1);
                end else begin
                    l = exp_lvl.pop_front();
                    chk("busy", int'(busy), int'(l.busy));
                    chk("ev_ready", int'(ev_ready), int'(l.ready));
                    chk("ev_drop", int'(ev_drop), int'(l.drop));
                end
                if (!play_sound) chk("code_when_silent", int'(sound_code), 0);
                if (play_sound && !playing) begin
                    playing = 1'b1;
                    pst = cyc_n;
                    pcode = int'(sound_code);
                end else if (play_sound && playing) begin
                    if (int'(sound_code) != pcode) chk("code_hold", int'(sound_code), pcode);
                end else if (!play_sound && playing) begin
                    playing = 1'b0;
                    snd_seen++;
                    if (exp_snd.size() == 0) begin
                        chk("sound_expected", exp_snd.size(), 1);
                    end else begin
                        s = exp_snd.pop_front();
                        chk("sound_code", pcode, s.code);
                        chk("sound_start", pst, s.start);
                        chk("sound_dur", cyc_n - pst, s.dur);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int burst;
        bit v;

        // Reset and quiet idle
        do_reset(3);
        idle_until(20);
        chk("idle_play", int'(play_sound), 0);

        // Single event
        do_reset(2);
        step(1'b1, 3'd3);
        idle_until(2);
        chk("single_c2_play", int'(play_sound), 1);
        chk("single_c2_code", int'(sound_code), 3);
        idle_until(193);
        chk("single_c193_play", int'(play_sound), 1);
        idle_until(194);
        chk("single_c194_play", int'(play_sound), 0);
        idle_until(201);
        chk("single_c201_busy", int'(busy), 1);
        idle_until(202);
        chk("single_c202_busy", int'(busy), 0);
        drain();

        // Back-to-back
        do_reset(2);
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        idle_until(257);
        chk("b2b_c257_code", int'(sound_code), 1);
        idle_until(258);
        chk("b2b_c258_play", int'(play_sound), 0);
        idle_until(266);
        chk("b2b_c266_play", int'(play_sound), 0);
        idle_until(267);
        chk("b2b_c267_code", int'(sound_code), 2);
        idle_until(458);
        chk("b2b_c458_play", int'(play_sound), 1);
        idle_until(459);
        chk("b2b_c459_play", int'(play_sound), 0);
        drain();

        // Overflow
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b1, 3'd3);
        chk("ovf_c5_ready", int'(ev_ready), 0);
        step(1'b0, 3'd0);
        chk("ovf_c6_drop", int'(ev_drop), 1);
        step(1'b0, 3'd0);
        chk("ovf_c7_drop", int'(ev_drop), 0);
        drain();
        chk("ovf_sound_count", snd_seen, 5);

        // Game-over event while code 3 plays with two entries queued
        do_reset(2);
        step(1'b1, 3'd3);
        idle_until(9);
        step(1'b1, 3'd4);
        step(1'b1, 3'd5);
        idle_until(49);
        step(1'b1, 3'd7);
        step(1'b0, 3'd0);
        chk("pre_c51_busy", int'(busy), 1);
`ifdef SND_PREEMPT_EN
        chk("pre_c51_play", int'(play_sound), 0);
        idle_until(60);
        chk("pre_c60_code", int'(sound_code), 7);
        idle_until(252);
        chk("pre_c252_play", int'(play_sound), 0);
        drain();
        chk("pre_sound_count", snd_seen, 2);
`else
        chk("pre_c51_play", int'(play_sound), 1);
        drain();
        chk("pre_sound_count", snd_seen, 4);
`endif

        // Reset mid-play
        do_reset(2);
        step(1'b1, 3'd3);
        step(1'b1, 3'd5);
        step(1'b1, 3'd2);
        idle_until(100);
        chk("midrst_c100_play", int'(play_sound), 1);
        do_reset(2);
        idle_until(200);
        chk("midrst_quiet_sounds", snd_seen, 0);
        step(1'b1, 3'd6);
        drain();
        chk("midrst_new_sound", snd_seen, 1);

        // Randomised traffic including bursts that overflow the queue
        do_reset(2);
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(3, 7);
            v = (burst > 0) || ($urandom_range(0, 59) == 0);
            if (burst > 0) burst--;
            step(v, 3'($urandom_range(0, 7)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
